// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: latches level/edge sources into PENDING, masks with ENABLE,
// reports the lowest-index active source and drives a registered irq_o to the CPU.
module wb_irq_ctrl #(
    parameter int NUM_IRQ = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [7:0]         wb_addr_i,
    input  logic [31:0]        wb_data_i,
    input  logic [3:0]         wb_sel_i,
    output logic               wb_stall_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic [31:0]        wb_data_o,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               irq_o
);

    // Registers are kept 32 bits wide; bits at or above NUM_IRQ are forced to zero by this mask.
    localparam logic [31:0] IRQ_MASK = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << NUM_IRQ) - 32'd1);

    localparam logic [7:0] ADDR_STATUS  = 8'h0;
    localparam logic [7:0] ADDR_PENDING = 8'h1;
    localparam logic [7:0] ADDR_ENABLE  = 8'h2;
    localparam logic [7:0] ADDR_EDGE    = 8'h3;
    localparam logic [7:0] ADDR_ACTIVE  = 8'h4;

    logic        req;
    logic        mapped;
    logic        wr;
    logic [31:0] irq_ext;
    logic [31:0] byte_mask;
    logic [31:0] wr_bits;
    logic [31:0] set_bits;
    logic [31:0] clr_bits;
    logic [31:0] active_bits;
    logic [31:0] rdata;
    logic [31:0] pending_q;
    logic [31:0] enable_q;
    logic [31:0] edge_q;
    logic [31:0] irq_q;
    logic [4:0]  active_idx;
    logic        active_valid;

    assign wb_stall_o = 1'b0;

    assign req       = wb_cyc_i & wb_stb_i;
    assign mapped    = (wb_addr_i <= ADDR_ACTIVE);
    assign wr        = req & wb_we_i & mapped;
    assign irq_ext   = 32'(irq_i) & IRQ_MASK;
    assign byte_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wr_bits   = wb_data_i & byte_mask & IRQ_MASK;

    // Edge-mode sources only set on a 0->1 transition; level sources set whenever high.
    assign set_bits    = irq_ext & ~(edge_q & irq_q);
    assign clr_bits    = (wr && wb_addr_i == ADDR_PENDING) ? wr_bits : 32'h0;
    assign active_bits = pending_q & enable_q;
    assign active_valid = |active_bits;

    always_comb begin
        active_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (active_bits[i]) begin
                active_idx = 5'(i);
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (wb_addr_i)
            ADDR_STATUS:  rdata = irq_ext;
            ADDR_PENDING: rdata = pending_q;
            ADDR_ENABLE:  rdata = enable_q;
            ADDR_EDGE:    rdata = edge_q;
            ADDR_ACTIVE:  rdata = active_valid ? {1'b1, 26'h0, active_idx} : 32'h0;
            default:      rdata = 32'h0;
        endcase
    end

    // A set in the same cycle as a W1C clear wins, so no interrupt is lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 32'h0;
            enable_q  <= 32'h0;
            edge_q    <= 32'h0;
            irq_q     <= 32'h0;
            irq_o     <= 1'b0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_data_o <= 32'h0;
        end else begin
            irq_q     <= irq_ext;
            pending_q <= set_bits | (pending_q & ~clr_bits);
            if (wr && wb_addr_i == ADDR_ENABLE) begin
                enable_q <= (enable_q & ~byte_mask) | wr_bits;
            end
            if (wr && wb_addr_i == ADDR_EDGE) begin
                edge_q <= (edge_q & ~byte_mask) | wr_bits;
            end
            irq_o     <= active_valid;
            wb_ack_o  <= req & mapped;
            wb_err_o  <= req & ~mapped;
            wb_data_o <= (req && mapped && !wb_we_i) ? rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Directed bench for wb_irq_ctrl: bus responses are predicted into a scoreboard queue when
// each access is driven and compared when the response cycle arrives.
module tb_wb_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [7:0]  wb_addr_i = 8'h0;
    logic [31:0] wb_data_i = 32'h0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic        wb_stall_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] wb_data_o;
    logic [15:0] irq_i = 16'h0;
    logic        irq_o;

    int checks = 0;
    int failures = 0;

    string       tag_q[$];
    logic        ack_q[$];
    logic        err_q[$];
    logic [31:0] data_q[$];
    bit          chk_q[$];

    wb_irq_ctrl #(.NUM_IRQ(16)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .wb_sel_i   (wb_sel_i),
        .wb_stall_o (wb_stall_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_data_o  (wb_data_o),
        .irq_i      (irq_i),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Pops the oldest prediction and compares it with the response now on the bus.
    task automatic checkOutput();
        string       tag;
        logic [31:0] exp_data;
        bit          chk;
        checkValue("scoreboard_nonempty", 32'(tag_q.size() != 0), 32'd1);
        if (tag_q.size() != 0) begin
            tag      = tag_q.pop_front();
            exp_data = data_q.pop_front();
            chk      = chk_q.pop_front();
            checkValue({tag, "_ack"}, 32'(wb_ack_o), 32'(ack_q.pop_front()));
            checkValue({tag, "_err"}, 32'(wb_err_o), 32'(err_q.pop_front()));
            if (chk) checkValue({tag, "_data"}, wb_data_o, exp_data);
        end
    endtask

    // Drives one single-cycle request, records its expected response, then checks it next cycle.
    task automatic applyStimulus(input string tag, input logic we, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [3:0] sel,
                                 input logic exp_err, input logic [31:0] exp_data);
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_we_i   = we;
        wb_addr_i = addr;
        wb_data_i = data;
        wb_sel_i  = sel;
        tag_q.push_back(tag);
        ack_q.push_back(!exp_err);
        err_q.push_back(exp_err);
        data_q.push_back(exp_data);
        chk_q.push_back(!we || exp_err);
        tick();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        checkOutput();
    endtask

    task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        applyStimulus(tag, 1'b0, addr, 32'h0, 4'hF, 1'b0, exp);
    endtask

    task automatic wr(input string tag, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] sel);
        applyStimulus(tag, 1'b1, addr, data, sel, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset state and register map with no sources active
        #2;
        checkValue("rst_ack", 32'(wb_ack_o), 32'd0);
        checkValue("rst_err", 32'(wb_err_o), 32'd0);
        checkValue("rst_data", wb_data_o, 32'h0);
        checkValue("rst_irq", 32'(irq_o), 32'd0);
        checkValue("stall", 32'(wb_stall_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        for (int a = 0; a < 5; a++) rd($sformatf("init_rd%0d", a), 8'(a), 32'h0);
        checkValue("init_irq", 32'(irq_o), 32'd0);
        applyStimulus("rd_unmapped", 1'b0, 8'h05, 32'h0, 4'hF, 1'b1, 32'h0);
        checkValue("idle_ack", 32'(wb_ack_o), 32'd0);

        // Level source pulse, irq latency and W1C clear
        wr("en0", 8'h2, 32'h1, 4'hF);
        irq_i = 16'h0001;
        tick();
        irq_i = 16'h0000;
        checkValue("lvl_irq_k", 32'(irq_o), 32'd0);
        tick();
        checkValue("lvl_irq_k1", 32'(irq_o), 32'd1);
        rd("lvl_pend", 8'h1, 32'h1);
        rd("lvl_active", 8'h4, 32'h8000_0000);
        wr("lvl_w1c", 8'h1, 32'h1, 4'hF);
        checkValue("lvl_irq_after_w1c", 32'(irq_o), 32'd1);
        tick();
        checkValue("lvl_irq_cleared", 32'(irq_o), 32'd0);

        // Edge capture on a held source
        wr("edge2", 8'h3, 32'h4, 4'hF);
        wr("en2", 8'h2, 32'h4, 4'hF);
        irq_i = 16'h0004;
        tick();
        tick();
        checkValue("edge_irq", 32'(irq_o), 32'd1);
        rd("edge_pend", 8'h1, 32'h4);
        wr("edge_w1c", 8'h1, 32'h4, 4'hF);
        repeat (3) tick();
        checkValue("edge_irq_cleared", 32'(irq_o), 32'd0);
        rd("edge_pend_held", 8'h1, 32'h0);
        irq_i = 16'h0000;
        tick();

        // Priority, upper-bit masking, STATUS and unmapped/RO writes
        wr("edge_off", 8'h3, 32'h0, 4'hF);
        wr("en_all", 8'h2, 32'hFFFF_FFFF, 4'hF);
        rd("en_width", 8'h2, 32'h0000_FFFF);
        irq_i = 16'h0028;
        tick();
        rd("status", 8'h0, 32'h0000_0028);
        rd("prio_3", 8'h4, 32'h8000_0003);
        irq_i = 16'h0020;
        wr("clr3", 8'h1, 32'h8, 4'hF);
        rd("prio_5", 8'h4, 32'h8000_0005);
        irq_i = 16'h0000;
        wr("clr5", 8'h1, 32'h20, 4'hF);
        rd("pend_empty", 8'h1, 32'h0);
        applyStimulus("wr_unmapped", 1'b1, 8'h10, 32'h0, 4'hF, 1'b1, 32'h0);
        wr("wr_status", 8'h0, 32'hFFFF_FFFF, 4'hF);
        rd("en_kept", 8'h2, 32'h0000_FFFF);
        rd("status_ro", 8'h0, 32'h0);

        // Set beats a simultaneous W1C clear
        wr("edge1", 8'h3, 32'h2, 4'hF);
        irq_i = 16'h0002;
        wr("race_w1c", 8'h1, 32'h2, 4'hF);
        rd("race_pend", 8'h1, 32'h2);
        irq_i = 16'h0000;
        wr("race_clr", 8'h1, 32'h2, 4'hF);
        rd("race_pend_clr", 8'h1, 32'h0);

        // Byte enables, then reset during an outstanding read
        wr("en_zero", 8'h2, 32'h0, 4'hF);
        wr("en_byte0", 8'h2, 32'hFFFF, 4'b0001);
        rd("en_sel", 8'h2, 32'h0000_00FF);
        wr("edge_byte1", 8'h3, 32'hFFFF, 4'b0010);
        rd("edge_sel", 8'h3, 32'h0000_FF02);
        irq_i = 16'h0001;
        tick();
        irq_i = 16'h0000;
        tick();
        checkValue("pre_rst_irq", 32'(irq_o), 32'd1);
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_we_i   = 1'b0;
        wb_addr_i = 8'h2;
        #2;
        rst_ni = 1'b0;
        #1;
        checkValue("mid_rst_ack", 32'(wb_ack_o), 32'd0);
        checkValue("mid_rst_irq", 32'(irq_o), 32'd0);
        tick();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        rst_ni   = 1'b1;
        tick();
        checkValue("post_rst_ack0", 32'(wb_ack_o), 32'd0);
        tick();
        checkValue("post_rst_ack1", 32'(wb_ack_o), 32'd0);
        rd("post_rst_pend", 8'h1, 32'h0);
        rd("post_rst_en", 8'h2, 32'h0);
        rd("post_rst_edge", 8'h3, 32'h0);
        rd("post_rst_active", 8'h4, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
